// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RV32I width codes,
// the request payload and a funct3 legality helper.
package lsu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned F3_WIDTH = 3;
    localparam int unsigned RD_WIDTH = 5;

    localparam logic [F3_WIDTH-1:0] F3_B  = 3'b000;
    localparam logic [F3_WIDTH-1:0] F3_H  = 3'b001;
    localparam logic [F3_WIDTH-1:0] F3_W  = 3'b010;
    localparam logic [F3_WIDTH-1:0] F3_BU = 3'b100;
    localparam logic [F3_WIDTH-1:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_RESPOND
    } lsu_state_e;

    typedef struct packed {
        logic                write;
        logic [F3_WIDTH-1:0] funct3;
        logic [XLEN-1:0]     addr;
        logic [XLEN-1:0]     wdata;
        logic [RD_WIDTH-1:0] rd;
    } lsu_req_t;

    // Unsigned widths exist only for loads.
    function automatic logic funct3_legal(input logic write, input logic [F3_WIDTH-1:0] funct3);
        logic legal;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !write;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-request / response / data-memory bundle of the load/store unit.
// slave  : the load/store unit itself.
// master : the surrounding core + memory.
interface lsu_if #(
    parameter int unsigned ADDR_WIDTH = 4
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic [4:0]            req_rd;
    logic                  rsp_valid;
    logic [31:0]           rsp_data;
    logic [4:0]            rsp_rd;
    logic                  rsp_fault;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_fault, busy,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_fault, busy,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends load data from a memory word
// and merges sub-word store data into the word read back from memory.
//   funct3, byte_off    : latched width code and addr[1:0]
//   mem_rdata, req_wdata: word read from memory, latched store data
//   load_data_c         : extended load result
//   store_word_c        : full word to write back
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [F3_WIDTH-1:0] funct3,
    input  logic [1:0]          byte_off,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic [XLEN-1:0]     req_wdata,
    output logic [XLEN-1:0]     load_data_c,
    output logic [XLEN-1:0]     store_word_c
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane    = mem_rdata[{byte_off, 3'b000} +: 8];
        half_lane    = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data_c  = mem_rdata;
        store_word_c = req_wdata;
        case (funct3)
            F3_B: begin
                load_data_c  = {{24{byte_lane[7]}}, byte_lane};
                store_word_c = mem_rdata;
                store_word_c[{byte_off, 3'b000} +: 8] = req_wdata[7:0];
            end
            F3_BU: load_data_c = {24'd0, byte_lane};
            F3_H: begin
                load_data_c  = {{16{half_lane[15]}}, half_lane};
                store_word_c = byte_off[1] ? {req_wdata[15:0], mem_rdata[15:0]}
                                           : {mem_rdata[31:16], req_wdata[15:0]};
            end
            F3_HU:   load_data_c = {16'd0, half_lane};
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Sequences one byte-addressed load/store at a time onto a word-addressed
// memory with a registered read port. Sub-word stores are read-modify-write.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/response handshake and data-memory port (lsu_if.slave)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);
    lsu_state_e state_q, state_d;
    lsu_req_t   req_in;

    logic accept_c, fault_c, misaligned_c, out_of_range_c, req_ready_c, busy_c, mem_we_c;

    logic                  write_q;
    logic [F3_WIDTH-1:0]   funct3_q;
    logic [1:0]            byte_off_q;
    logic [XLEN-1:0]       wdata_q;
    logic [RD_WIDTH-1:0]   rd_q;

    logic [XLEN-1:0]       load_data_c, store_word_c;

    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [XLEN-1:0]       mem_wdata_q;
    logic                  rsp_valid_q, rsp_fault_q;
    logic [XLEN-1:0]       rsp_data_q;
    logic [RD_WIDTH-1:0]   rsp_rd_q;

    assign req_in = '{write:  bus.req_write,
                      funct3: bus.req_funct3,
                      addr:   bus.req_addr,
                      wdata:  bus.req_wdata,
                      rd:     bus.req_rd};

    // Fault check on the incoming request; faults skip memory entirely.
    always_comb begin
        misaligned_c = 1'b0;
        case (req_in.funct3)
            F3_H, F3_HU: misaligned_c = req_in.addr[0];
            F3_W:        misaligned_c = (req_in.addr[1:0] != 2'b00);
            default:     misaligned_c = 1'b0;
        endcase
        out_of_range_c = (req_in.addr >> (ADDR_WIDTH + 2)) != XLEN'(0);
        fault_c = !funct3_legal(req_in.write, req_in.funct3) || misaligned_c || out_of_range_c;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state plus the handshake/strobe outputs that must drop with rst.
    always_comb begin
        state_d     = state_q;
        req_ready_c = (state_q == S_IDLE) && !rst;
        busy_c      = (state_q != S_IDLE) && !rst;
        mem_we_c    = (state_q == S_WRITE) && !rst;
        accept_c    = bus.req_valid && req_ready_c;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (fault_c)                                 state_d = S_RESPOND;
                    else if (req_in.write && req_in.funct3 == F3_W) state_d = S_WRITE;
                    else                                         state_d = S_READ;
                end
            end
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = write_q ? S_WRITE : S_RESPOND;
            S_WRITE:   state_d = S_RESPOND;
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    lsu_lane_align u_lane_align (
        .funct3       (funct3_q),
        .byte_off     (byte_off_q),
        .mem_rdata    (bus.mem_rdata),
        .req_wdata    (wdata_q),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    // Request latches, word buffer (doubles as mem_wdata) and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q     <= 1'b0;
            funct3_q    <= '0;
            byte_off_q  <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
        end else begin
            rsp_valid_q <= (state_d == S_RESPOND);
            if (accept_c) begin
                write_q    <= req_in.write;
                funct3_q   <= req_in.funct3;
                byte_off_q <= req_in.addr[1:0];
                wdata_q    <= req_in.wdata;
                rd_q       <= req_in.rd;
                mem_addr_q <= req_in.addr[ADDR_WIDTH+1:2];
                if (fault_c) begin
                    rsp_fault_q <= 1'b1;
                    rsp_data_q  <= '0;
                    rsp_rd_q    <= req_in.write ? RD_WIDTH'(0) : req_in.rd;
                end else if (req_in.write && req_in.funct3 == F3_W) begin
                    mem_wdata_q <= req_in.wdata;
                end
            end
            if (state_q == S_CAPTURE) begin
                mem_wdata_q <= write_q ? store_word_c : bus.mem_rdata;
                if (!write_q) begin
                    rsp_fault_q <= 1'b0;
                    rsp_data_q  <= load_data_c;
                    rsp_rd_q    <= rd_q;
                end
            end
            if (state_q == S_WRITE) begin
                rsp_fault_q <= 1'b0;
                rsp_data_q  <= '0;
                rsp_rd_q    <= '0;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.busy      = busy_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_rd    = rsp_rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural memory/reference model
// predicts each response and memory write; a monitor compares them.
module tb_load_store_unit;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst;

    lsu_if #(.ADDR_WIDTH(AW)) bus ();

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fault;
        int          cyc;
    } exp_rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } exp_wr_t;

    exp_rsp_t    rsp_q[$];
    exp_wr_t     wr_q[$];
    exp_rsp_t    mon_r;
    exp_wr_t     mon_w;
    logic [31:0] phys[DEPTH];
    logic [31:0] ref_mem[DEPTH];
    int          cyc   = 0;
    int          tests = 0;
    int          fails = 0;
    int          acc_a, acc_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory with one-cycle registered read.
    always @(posedge clk) begin
        bus.mem_rdata <= phys[bus.mem_addr];
        if (bus.mem_we) phys[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed memory semantics computed arithmetically.
    function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [4:0] rd,
                                  output exp_rsp_t r, output logic wr_en, output exp_wr_t wr,
                                  output int k);
        int          size, off, idx;
        logic        legal;
        logic [31:0] mask, v, word;
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        off     = int'(a % 4);
        idx     = int'((a / 4) % DEPTH);
        r.data  = 32'd0;
        r.rd    = w ? 5'd0 : rd;
        r.fault = 1'b0;
        r.cyc   = 0;
        wr_en   = 1'b0;
        wr.addr = AW'(idx);
        wr.data = 32'd0;
        wr.cyc  = 0;
        if (!legal || (a % size) != 0 || a >= 4 * DEPTH) begin
            r.fault = 1'b1;
            k = 1;
        end else if (!w) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
            v = (ref_mem[idx] >> (8 * off)) & mask;
            if (f3 < 3'd4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
            r.data = v;
            k = 3;
        end else begin
            if (size == 4) begin
                word = wd;
                k = 2;
            end else begin
                mask = ((32'd1 << (8 * size)) - 32'd1) << (8 * off);
                word = (ref_mem[idx] & ~mask) | ((wd << (8 * off)) & mask);
                k = 4;
            end
            ref_mem[idx] = word;
            wr_en   = 1'b1;
            wr.data = word;
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input bit hold, input bit expect_it, output int acc);
        exp_rsp_t r;
        exp_wr_t  wr;
        logic     wr_en;
        int       k;
        int       n;
        n = 0;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        #1;
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, expected 1", n);
            bus.req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        if (expect_it) begin
            model(w, f3, a, wd, rd, r, wr_en, wr, k);
            r.cyc = cyc + k;
            rsp_q.push_back(r);
            if (wr_en) begin
                wr.cyc = cyc + k - 1;
                wr_q.push_back(wr);
            end
        end
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0 || !bus.req_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: %0d responses and %0d writes still pending, expected 0",
                     rsp_q.size(), wr_q.size());
        end
    endtask

    task automatic check_mem();
        for (int i = 0; i < int'(DEPTH); i++) check($sformatf("mem_word_%0d", i), phys[i], ref_mem[i]);
    endtask

    // Monitor: compares every response pulse and write strobe with the scoreboard.
    always begin
        @(negedge clk);
        #2;
        if (!rst) check("busy_vs_ready", 32'(bus.busy), 32'(!bus.req_ready));
        if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected 0", cyc);
            end else begin
                mon_r = rsp_q.pop_front();
                check("rsp_data", bus.rsp_data, mon_r.data);
                check("rsp_rd", 32'(bus.rsp_rd), 32'(mon_r.rd));
                check("rsp_fault", 32'(bus.rsp_fault), 32'(mon_r.fault));
                check("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
            end
        end
        if (bus.mem_we) begin
            if (wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_we: mem_we=1 at cycle %0d addr %0d, expected 0", cyc, bus.mem_addr);
            end else begin
                mon_w = wr_q.pop_front();
                check("we_addr", 32'(bus.mem_addr), 32'(mon_w.addr));
                check("we_data", bus.mem_wdata, mon_w.data);
                check("we_cycle", 32'(cyc), 32'(mon_w.cyc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_rd     = 5'd0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'd0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        // SW then preload the remaining words.
        issue(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, acc_a);
        wait_idle();
        check("sw_word2", phys[2], 32'hDEADBEEF);
        for (int i = 0; i < int'(DEPTH); i++)
            if (i != 2) issue(1'b1, 3'd2, 32'(4 * i), $urandom, 5'd0, 1'b0, 1'b1, acc_a);

        // Lane extraction and sign/zero extension.
        issue(1'b0, 3'd0, 32'hB, 32'd0, 5'd5, 1'b0, 1'b1, acc_a);
        issue(1'b0, 3'd4, 32'hB, 32'd0, 5'd5, 1'b0, 1'b1, acc_a);
        issue(1'b0, 3'd1, 32'hA, 32'd0, 5'd5, 1'b0, 1'b1, acc_a);
        issue(1'b0, 3'd5, 32'hA, 32'd0, 5'd5, 1'b0, 1'b1, acc_a);
        issue(1'b0, 3'd2, 32'h8, 32'd0, 5'd5, 1'b0, 1'b1, acc_a);

        // Read-modify-write stores.
        issue(1'b1, 3'd0, 32'h9, 32'h11, 5'd0, 1'b0, 1'b1, acc_a);
        wait_idle();
        check("sb_word2", phys[2], 32'hDEAD11EF);
        issue(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, acc_a);
        issue(1'b1, 3'd1, 32'hA, 32'h1234, 5'd0, 1'b0, 1'b1, acc_a);
        wait_idle();
        check("sh_word2", phys[2], 32'h1234BEEF);

        // Faults: misaligned, illegal funct3, out of range.
        issue(1'b0, 3'd2, 32'h6, 32'd0, 5'd3, 1'b0, 1'b1, acc_a);
        issue(1'b1, 3'd1, 32'h3, 32'hFFFF, 5'd0, 1'b0, 1'b1, acc_a);
        issue(1'b0, 3'd3, 32'h8, 32'd0, 5'd4, 1'b0, 1'b1, acc_a);
        issue(1'b0, 3'd2, 32'h40, 32'd0, 5'd6, 1'b0, 1'b1, acc_a);
        issue(1'b1, 3'd4, 32'h4, 32'h77, 5'd0, 1'b0, 1'b1, acc_a);
        wait_idle();
        check_mem();

        // Reset during the WRITE state of an SB: transaction abandoned.
        issue(1'b1, 3'd0, 32'h9, 32'h55, 5'd0, 1'b0, 1'b0, acc_a);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("we_in_rst", 32'(bus.mem_we), 32'd0);
        check("ready_in_rst", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_midrst", 32'(bus.req_ready), 32'd1);
        check("no_rsp_after_midrst", 32'(bus.rsp_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("word2_after_midrst", phys[2], ref_mem[2]);

        // Back-to-back loads with req_valid held high.
        issue(1'b0, 3'd2, 32'h8, 32'd0, 5'd9, 1'b1, 1'b1, acc_a);
        issue(1'b0, 3'd2, 32'hC, 32'd0, 5'd10, 1'b0, 1'b1, acc_b);
        check("b2b_spacing", 32'(acc_b - acc_a), 32'd4);
        wait_idle();

        // Random mix, mostly in range, with random back-to-back holding.
        for (int n = 0; n < 300; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), f3, a, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'b1, acc_a);
        end
        bus.req_valid = 1'b0;
        wait_idle();
        check_mem();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
